// File: rtl/matrix_pkg.sv
// Shared definitions for the LED matrix scheduler.
//   state_e      : scheduler FSM states (IDLE, SCAN)
//   REQ_*        : bit index of each requester inside the 3-bit req vector
//   ROW_BLANK    : active-low row select value with every row off
//   prio_encode  : fixed-priority one-hot encode (bit2 > bit1 > bit0)
//   row_select   : active-low row select pattern for a given row index
package matrix_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam int REQ_SUCCESS = 2;
  localparam int REQ_FAIL    = 1;
  localparam int REQ_COUNT   = 0;

  localparam logic [7:0] ROW_BLANK = 8'hFF;

  function automatic logic [2:0] prio_encode(input logic [2:0] req);
    logic [2:0] onehot;
    onehot = 3'b000;
    if (req[REQ_SUCCESS])    onehot = 3'b100;
    else if (req[REQ_FAIL])  onehot = 3'b010;
    else if (req[REQ_COUNT]) onehot = 3'b001;
    return onehot;
  endfunction

  // Row r pulls bit (7-r) low.
  function automatic logic [7:0] row_select(input logic [2:0] row);
    return ~(8'h80 >> row);
  endfunction

endpackage

// File: rtl/matrix_row_timer.sv
// Dwell counter and row pointer for the matrix scan.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : force row 0 / dwell 0 on the next edge (wins over enable)
//   enable      : advance dwell; wraps to the next row after DWELL_CYCLES
//   scan_row    : current row index (registered)
//   row_start   : dwell == 0 (blanking cycle of the row)
//   row_end     : dwell == DWELL_CYCLES-1
//   frame_end   : row 7 and dwell == DWELL_CYCLES-1
module matrix_row_timer #(
  parameter int DWELL_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  output logic [2:0] scan_row,
  output logic       row_start,
  output logic       row_end,
  output logic       frame_end
);

  localparam logic [7:0] DWELL_LAST = 8'(DWELL_CYCLES - 1);

  logic [7:0] dwell_q, dwell_d;
  logic [2:0] row_q, row_d;

  always_comb begin
    dwell_d = dwell_q;
    row_d   = row_q;
    if (clear) begin
      dwell_d = 8'd0;
      row_d   = 3'd0;
    end else if (enable) begin
      if (dwell_q == DWELL_LAST) begin
        dwell_d = 8'd0;
        row_d   = row_q + 3'd1;  // 3-bit wrap gives modulo 8
      end else begin
        dwell_d = dwell_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q <= 8'd0;
      row_q   <= 3'd0;
    end else begin
      dwell_q <= dwell_d;
      row_q   <= row_d;
    end
  end

  assign scan_row  = row_q;
  assign row_start = (dwell_q == 8'd0);
  assign row_end   = (dwell_q == DWELL_LAST);
  assign frame_end = row_end && (row_q == 3'd7);

endmodule

// File: rtl/led_matrix_scheduler.sv
// Arbitrates three display requesters onto one 8x8 LED matrix and scans it
// row by row with a blanking cycle at the start of every row.
//   clk, rst_n        : clock, asynchronous active-low reset
//   req[2:0]          : display requests (bit2 success, bit1 fail, bit0 count)
//   row_data0/1/2     : column data of requester n for row scan_row
//   scan_row[2:0]     : row being fetched (registered)
//   grant[2:0]        : one-hot owner, 000 when idle (registered)
//   hang[7:0]         : active-low row select
//   gre[7:0]          : active-high green column drive
//   frame_done        : one-cycle pulse on the last cycle of row 7
// Handshake: req is a level; a requester keeps its bit high for as long as
// it wants the display and may drop it at any time. grant changes only at
// frame end, on owner drop, or when leaving IDLE.
module led_matrix_scheduler
  import matrix_pkg::*;
#(
  parameter int DWELL_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic [7:0] row_data0,
  input  logic [7:0] row_data1,
  input  logic [7:0] row_data2,
  output logic [2:0] scan_row,
  output logic [2:0] grant,
  output logic [7:0] hang,
  output logic [7:0] gre,
  output logic       frame_done
);

  state_e     state_q, state_d;
  logic [2:0] grant_q, grant_d;
  logic [7:0] gre_q, gre_d;
  logic [7:0] hang_q, hang_d;

  logic       owner_held;
  logic       timer_clear;
  logic       row_start, row_end, frame_end;
  logic [7:0] sel_data;

  matrix_row_timer #(.DWELL_CYCLES(DWELL_CYCLES)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (timer_clear),
    .enable    (owner_held),
    .scan_row  (scan_row),
    .row_start (row_start),
    .row_end   (row_end),
    .frame_end (frame_end)
  );

  // Only the granted requester's data is ever looked at.
  always_comb begin
    sel_data = 8'h00;
    unique case (grant_q)
      3'b100:  sel_data = row_data2;
      3'b010:  sel_data = row_data1;
      3'b001:  sel_data = row_data0;
      default: sel_data = 8'h00;
    endcase
  end

  // Scanning continues only while the current owner still requests.
  assign owner_held = (state_q == SCAN) && (|(grant_q & req));

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gre_d       = gre_q;
    hang_d      = hang_q;
    timer_clear = 1'b0;
    if (owner_held) begin
      // Timer wraps to row 0 by itself; only the owner is re-chosen here.
      if (frame_end) grant_d = prio_encode(req);
      if (row_start) begin
        gre_d  = sel_data;
        hang_d = row_select(scan_row);
      end else if (row_end) begin
        // Next cycle is the blanking cycle of the following row.
        gre_d  = 8'h00;
        hang_d = ROW_BLANK;
      end
    end else begin
      // Idle, leaving idle, or owner dropped: restart from a blank row 0.
      timer_clear = 1'b1;
      grant_d     = prio_encode(req);
      state_d     = (req != 3'b000) ? SCAN : IDLE;
      gre_d       = 8'h00;
      hang_d      = ROW_BLANK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 3'b000;
      gre_q   <= 8'h00;
      hang_q  <= ROW_BLANK;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gre_q   <= gre_d;
      hang_q  <= hang_d;
    end
  end

  assign grant      = grant_q;
  assign gre        = gre_q;
  assign hang       = hang_q;
  assign frame_done = (state_q == SCAN) && frame_end;

endmodule

// File: tb/tb_led_matrix_scheduler.sv
module tb_led_matrix_scheduler;

  localparam int D     = 4;
  localparam int FRAME = 8 * D;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req = 3'b000;
  logic [7:0] tbl [3][8];
  logic [7:0] row_data0, row_data1, row_data2;
  logic [2:0] scan_row, grant;
  logic [7:0] hang, gre;
  logic       frame_done;

  always #5 clk = ~clk;

  // Requesters answer combinationally for whatever row is being fetched.
  assign row_data0 = tbl[0][scan_row];
  assign row_data1 = tbl[1][scan_row];
  assign row_data2 = tbl[2][scan_row];

  led_matrix_scheduler #(.DWELL_CYCLES(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .row_data0  (row_data0),
    .row_data1  (row_data1),
    .row_data2  (row_data2),
    .scan_row   (scan_row),
    .grant      (grant),
    .hang       (hang),
    .gre        (gre),
    .frame_done (frame_done)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;
  int fd_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Owner index (-1 = idle) and position inside the frame (row*D + dwell).
  int         m_owner = -1;
  int         m_pos = 0;
  logic [7:0] m_data = 8'h00;

  function automatic int highest(input logic [2:0] r);
    if (r[2]) return 2;
    if (r[1]) return 1;
    if (r[0]) return 0;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1;
      m_pos   = 0;
      m_data  = 8'h00;
    end else if (m_owner >= 0 && req[m_owner]) begin
      if (m_pos % D == 0) m_data = tbl[m_owner][m_pos / D];
      if (m_pos == FRAME - 1) begin
        m_owner = highest(req);
        m_pos   = 0;
      end else begin
        m_pos = m_pos + 1;
      end
    end else begin
      m_owner = highest(req);
      m_pos   = 0;
    end
  end

  // ---------------- compare process ----------------
  logic [2:0] e_grant, e_row;
  logic [7:0] e_hang, e_gre;
  logic       e_fd;

  always @(negedge clk) begin
    if (m_owner < 0) begin
      e_grant = 3'b000; e_row = 3'd0; e_hang = 8'hFF; e_gre = 8'h00; e_fd = 1'b0;
    end else begin
      e_grant = 3'(1 << m_owner);
      e_row   = 3'(m_pos / D);
      e_hang  = (m_pos % D == 0) ? 8'hFF : ~(8'h80 >> (m_pos / D));
      e_gre   = (m_pos % D == 0) ? 8'h00 : m_data;
      e_fd    = (m_pos == FRAME - 1);
    end
    check("grant", 32'(grant), 32'(e_grant));
    check("scan_row", 32'(scan_row), 32'(e_row));
    check("hang", 32'(hang), 32'(e_hang));
    check("gre", 32'(gre), 32'(e_gre));
    check("frame_done", 32'(frame_done), 32'(e_fd));
    if (frame_done === 1'b1) fd_count++;
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fill_tbl(input logic [7:0] v, input bit rnd);
    for (int k = 0; k < 3; k++)
      for (int r = 0; r < 8; r++)
        tbl[k][r] = rnd ? 8'($urandom_range(0, 255)) : v;
  endtask

  // Advance to the negedge where the model sits at position pos.
  task automatic wait_pos(input int pos, input int budget, input string name);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (m_owner >= 0 && m_pos == pos) found = 1;
    end
    check({"wait_", name}, 32'(found), 32'd1);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_hang", 32'(hang), 32'hFF);
    check("rst_async_gre", 32'(gre), 32'h00);
    check("rst_async_grant", 32'(grant), 32'h0);
    cycles(2);
    #2 rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int fd_base;

  initial begin
    fill_tbl(8'h00, 1'b0);
    cycles(3);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_hang", 32'(hang), 32'hFF);
    check("reset_grant", 32'(grant), 32'h0);

    // Idle for 20 cycles: no frames.
    fd_base = fd_count;
    cycles(20);
    check("idle_no_frame", 32'(fd_count - fd_base), 32'd0);

    // Countdown owner with constant 0x66 data.
    fill_tbl(8'h66, 1'b0);
    req = 3'b001;
    @(negedge clk);
    check("cnt_grant", 32'(grant), 32'h1);
    check("cnt_blank", 32'(hang), 32'hFF);
    @(negedge clk);
    check("cnt_row0_hang", 32'(hang), 32'h7F);
    check("cnt_row0_gre", 32'(gre), 32'h66);
    fd_base = fd_count;
    cycles(64);
    check("cnt_frame_rate", 32'(fd_count - fd_base), 32'd2);

    // Higher-priority request mid-frame waits for frame end.
    fill_tbl(8'h00, 1'b1);
    req = 3'b000;
    @(negedge clk);
    req = 3'b001;
    wait_pos(3 * D, 100, "row3");
    req = 3'b101;
    wait_pos(FRAME - 1, 100, "frame_end");
    check("pre_arb_grant", 32'(grant), 32'h1);
    check("pre_arb_fd", 32'(frame_done), 32'h1);
    @(negedge clk);
    check("post_arb_grant", 32'(grant), 32'h4);
    check("post_arb_row", 32'(scan_row), 32'h0);

    // Owner drop at row 5 dwell 2.
    req = 3'b100;
    wait_pos(5 * D + 2, 100, "row5d2");
    req = 3'b010;
    @(negedge clk);
    check("drop_hang", 32'(hang), 32'hFF);
    check("drop_grant", 32'(grant), 32'h2);
    check("drop_row", 32'(scan_row), 32'h0);

    // Asynchronous reset at row 4 dwell 2, req held.
    wait_pos(4 * D + 1, 100, "row4d1");
    reset_pulse();
    cycles(2);
    check("after_rst_grant", 32'(grant), 32'h2);
    check("after_rst_row", 32'(scan_row), 32'h0);

    // Owner drop coinciding with frame end.
    req = 3'b001;
    wait_pos(FRAME - 1, 200, "fe_drop");
    check("fe_drop_fd", 32'(frame_done), 32'h1);
    req = 3'b000;
    @(negedge clk);
    check("fe_drop_grant", 32'(grant), 32'h0);
    check("fe_drop_hang", 32'(hang), 32'hFF);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0)
        tbl[$urandom_range(0, 2)][$urandom_range(0, 7)] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 599) == 0) reset_pulse();
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_matrix_scheduler.md
LED_MATRIX_SCHEDULER -- requirements
Module: led_matrix_scheduler

Interface
REQ-001 Parameter: DWELL_CYCLES, default 10, clock cycles each row is held per scan; legal range 2..255.
REQ-002 Port: clk  input  1  single system clock, all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: req  input  3  display requests; bit2 = success face, bit1 = failure face, bit0 = countdown digits.
REQ-005 Port: row_data0, row_data1, row_data2  input  8 each  green column data from requester n for row scan_row, combinational from requester.
REQ-006 Port: scan_row  output  3  row index currently being fetched, registered.
REQ-007 Port: grant  output  3  one-hot current owner, 000 when idle, registered.
REQ-008 Port: hang  output  8  active-low row select; row r drives bit (7-r) low, e.g. row 0 = 01111111.
REQ-009 Port: gre  output  8  green column drive, active-high.
REQ-010 Port: frame_done  output  1  one-cycle pulse at the end of each complete 8-row frame.

Function
REQ-011 States: IDLE and SCAN; IDLE when req==000, otherwise SCAN.
REQ-012 IDLE: hang=FF, gre=00, grant=000, scan_row=0, dwell counter=0, frame_done=0.
REQ-013 IDLE->SCAN on the first edge with req!=000: grant latches the highest set req bit (fixed priority bit2>bit1>bit0), scan_row=0, dwell=0.
REQ-014 SCAN: dwell counts 0..DWELL_CYCLES-1 per row, then scan_row increments modulo 8 and dwell returns to 0.
REQ-015 Blanking: during dwell==0 of every row, hang=FF and gre=00 (anti-ghosting).
REQ-016 At the edge ending dwell==0, gre latches row_data of the granted requester for scan_row and hang drives the row pattern for scan_row.
REQ-017 gre and hang then hold constant through dwell==DWELL_CYCLES-1 (latency: data visible one cycle after row start).
REQ-018 Frame end = scan_row==7 and dwell==DWELL_CYCLES-1; frame_done is high exactly that cycle.
REQ-019 Re-arbitration occurs only at frame end: the next grant is the highest pending req; a higher-priority request arriving mid-frame waits for frame end.
REQ-020 Owner drop: if the granted req bit is 0 at any SCAN edge, the next cycle blanks (hang=FF, gre=00), grant switches to the highest remaining req, and scan_row=0, dwell=0; if none remain, go to IDLE.
REQ-021 When owner drop and frame end coincide, REQ-020 governs; frame_done still pulses.
REQ-022 row_data inputs of non-granted requesters are ignored.
REQ-023 grant is always one-hot or zero; no output is X after reset.

Reset
REQ-024 rst_n low asynchronously forces IDLE: hang=FF, gre=00, grant=000, scan_row=0, frame_done=0, dwell=0.
REQ-025 Reset asserted mid-frame discards the frame; after release the block re-arbitrates from row 0 per REQ-013.

Structure
REQ-026 Shared package matrix_pkg holds: state enum {IDLE, SCAN}, requester index constants REQ_SUCCESS=2, REQ_FAIL=1, REQ_COUNT=0, ROW_BLANK=8'hFF, and a fixed-priority encode function.
REQ-027 One sub-module, matrix_row_timer, holds the dwell counter and row pointer and outputs the row_start and frame_end strobes; clear and enable inputs come from the parent FSM.

Verification (DWELL_CYCLES=4)
REQ-028 Reset, then req=000 for 20 cycles -> hang=FF, gre=00, grant=000, frame_done never high.
REQ-029 req=001, row_data0=8'h66 -> grant=001; per row 1 blank cycle, then 3 cycles of hang=~(8'h80>>r), gre=66; frame_done every 32 cycles.
REQ-030 req=001, then req=101 raised at row 3 -> grant stays 001 until frame_done, then becomes 100 and row 0 restarts.
REQ-031 req=100 owner, req drops to 010 at row 5 dwell 2 -> next cycle blank, grant=010, scan_row=0.
REQ-032 rst_n low at row 4 dwell 2 with req=010 held -> immediately hang=FF, gre=00, grant=000; after release grant=010 and scan starts at row 0.
REQ-033 Owner drop on the frame-end cycle with req=000 -> frame_done high for that cycle, next cycle IDLE.
